// File: rtl/mbgd_grad_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mbgd_grad_accum : per-lane err*x product accumulation over a mini-batch    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module mbgd_grad_accum #(
  parameter int N        = 8,
  parameter int DW       = 8,
  parameter int BATCH    = 4,
  parameter int CNT_W    = 8,
  parameter int ACC_W    = 24,
  parameter int LR_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [N*DW-1:0]    err,
  input  logic [N*DW-1:0]    x,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*ACC_W-1:0] grad,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(BATCH - 1);
  localparam int               c_pw   = 2 * DW;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_p_valid;

  logic w_accept;
  logic w_release;

  assign w_accept  = in_valid && r_in_ready;
  assign w_release = r_out_valid && out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  // Control FSM; in_ready/out_valid are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p_valid   <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p_valid   <= 1'b0;
    end else begin
      r_p_valid <= w_accept;
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (r_cnt == c_last) begin
              r_cnt      <= '0;
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (w_release) begin
            r_state     <= ST_ACCUM;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [c_pw-1:0]  w_err_ext;
    logic signed [c_pw-1:0]  w_x_ext;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [c_pw-1:0]  r_prod;
    logic signed [ACC_W-1:0] r_acc;

    // Operands widened first so the product is formed at full 2*DW precision.
    assign w_err_ext  = {{DW{err[i*DW+DW-1]}}, err[i*DW +: DW]};
    assign w_x_ext    = {{DW{x[i*DW+DW-1]}}, x[i*DW +: DW]};
    assign w_prod_ext = {{(ACC_W-c_pw){r_prod[c_pw-1]}}, r_prod};
    assign w_shifted  = r_acc >>> LR_SHIFT;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_prod <= '0;
        r_acc  <= '0;
      end else if (clear) begin
        r_prod <= '0;
        r_acc  <= '0;
      end else begin
        if (w_accept) begin
          r_prod <= w_err_ext * w_x_ext;
        end
        if (w_release) begin
          r_acc <= '0;
        end else if (r_p_valid) begin
          r_acc <= r_acc + w_prod_ext;
        end
      end
    end

    assign grad[i*ACC_W +: ACC_W] = r_out_valid ? w_shifted : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mbgd_grad_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mbgd_grad_accum : directed bench for mbgd_grad_accum (shift 0 and 2)    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module tb_mbgd_grad_accum;

  localparam int c_gw = 8 * 24;

  logic            clk;
  logic            reset;
  logic            clear;
  logic [63:0]     err;
  logic [63:0]     x;
  logic            in_valid;
  logic            out_ready;
  logic            in_ready0, in_ready2;
  logic            out_valid0, out_valid2;
  logic [c_gw-1:0] grad0, grad2;

  int total = 0;
  int bad   = 0;

  mbgd_grad_accum #(.N(8), .DW(8), .BATCH(4), .CNT_W(8), .ACC_W(24), .LR_SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clear), .err(err), .x(x), .in_valid(in_valid),
    .in_ready(in_ready0), .grad(grad0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  mbgd_grad_accum #(.N(8), .DW(8), .BATCH(4), .CNT_W(8), .ACC_W(24), .LR_SHIFT(2)) u_dut2 (
    .clk(clk), .reset(reset), .clear(clear), .err(err), .x(x), .in_valid(in_valid),
    .in_ready(in_ready2), .grad(grad2), .out_valid(out_valid2), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [c_gw-1:0] obs, input logic [c_gw-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [c_gw-1:0] fill(input logic [23:0] lo, input logic [23:0] hi);
    return {{4{hi}}, {4{lo}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [7:0] e_lo, input logic [7:0] e_hi,
                      input logic [7:0] x_lo, input logic [7:0] x_hi);
    err      = {{4{e_hi}}, {4{e_lo}}};
    x        = {{4{x_hi}}, {4{x_lo}}};
    in_valid = 1'b1;
    repeat (n) tick();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [c_gw-1:0] held0;

  initial begin
    reset = 1'b1; clear = 1'b0; err = '0; x = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk("reset_in_ready", c_gw'(in_ready0), c_gw'(1'b1));
    chk("reset_out_valid", c_gw'(out_valid0), c_gw'(1'b0));
    chk("reset_grad", grad0, '0);
    reset = 1'b0;

    // Basic batch: 3*5*4 = 60 per lane
    feed(2, 8'd3, 8'd3, 8'd5, 8'd5);
    chk("mid_batch_grad_zero", grad0, '0);
    feed(2, 8'd3, 8'd3, 8'd5, 8'd5);
    chk("drain_out_valid", c_gw'(out_valid0), c_gw'(1'b0));
    chk("drain_in_ready", c_gw'(in_ready0), c_gw'(1'b0));
    chk("drain_grad_zero", grad0, '0);
    tick();
    chk("basic_out_valid", c_gw'(out_valid0), c_gw'(1'b1));
    chk("basic_grad", grad0, fill(24'h00003C, 24'h00003C));
    chk("basic_grad_shift2", grad2, fill(24'h00000F, 24'h00000F));
    release_out();
    chk("release_in_ready", c_gw'(in_ready0), c_gw'(1'b1));
    chk("release_out_valid", c_gw'(out_valid0), c_gw'(1'b0));

    // Signed extremes
    feed(4, 8'h80, 8'hFF, 8'h80, 8'h7F);
    tick();
    chk("extreme_grad", grad0, fill(24'h010000, 24'hFFFE04));
    chk("extreme_grad_shift2", grad2, fill(24'h004000, 24'hFFFF81));

    // Backpressure with in_valid pulses that must be ignored
    held0 = grad0;
    err = {8{8'd9}}; x = {8{8'd9}};
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      tick();
      chk("bp_grad", grad0, held0);
      chk("bp_in_ready", c_gw'(in_ready0), c_gw'(1'b0));
      chk("bp_out_valid", c_gw'(out_valid0), c_gw'(1'b1));
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_release_in_ready", c_gw'(in_ready0), c_gw'(1'b1));
    feed(4, 8'd1, 8'd1, 8'd1, 8'd1);
    tick();
    chk("after_bp_grad", grad0, fill(24'h000004, 24'h000004));
    chk("after_bp_grad_shift2", grad2, fill(24'h000001, 24'h000001));
    release_out();

    // Clear with simultaneous in_valid drops that sample and the partial sums
    feed(2, 8'd1, 8'd1, 8'd1, 8'd1);
    clear = 1'b1; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_in_ready", c_gw'(in_ready0), c_gw'(1'b1));
    chk("clear_out_valid", c_gw'(out_valid0), c_gw'(1'b0));
    feed(3, 8'd2, 8'd2, 8'd2, 8'd2);
    chk("clear_count_restart", c_gw'(in_ready0), c_gw'(1'b1));
    feed(1, 8'd2, 8'd2, 8'd2, 8'd2);
    tick();
    chk("clear_batch_valid", c_gw'(out_valid0), c_gw'(1'b1));
    chk("clear_batch_grad", grad0, fill(24'h000010, 24'h000010));
    chk("clear_batch_grad_shift2", grad2, fill(24'h000004, 24'h000004));

    // Clear in DONE beats a simultaneous output handshake
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    chk("clear_done_out_valid", c_gw'(out_valid0), c_gw'(1'b0));
    chk("clear_done_in_ready", c_gw'(in_ready0), c_gw'(1'b1));

    // Asynchronous reset mid-batch
    feed(2, 8'd7, 8'd7, 8'd7, 8'd7);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_in_ready", c_gw'(in_ready0), c_gw'(1'b1));
    chk("async_reset_out_valid", c_gw'(out_valid0), c_gw'(1'b0));
    chk("async_reset_grad", grad0, '0);
    tick();
    reset = 1'b0;
    feed(4, 8'd1, 8'd1, 8'd2, 8'd2);
    tick();
    chk("post_reset_out_valid", c_gw'(out_valid0), c_gw'(1'b1));
    chk("post_reset_grad", grad0, fill(24'h000008, 24'h000008));
    chk("post_reset_grad_shift2", grad2, fill(24'h000002, 24'h000002));
    release_out();
    chk("final_in_ready", c_gw'(in_ready2), c_gw'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
